load_id_tracker: RTL and testbench
==================================

# load_id_tracker

Tracks outstanding load requests between the load unit and the data cache. Each load gets a buffer index that is sent with the cache request; the cache response comes back carrying that index. The tracker then restores the scoreboard transaction ID, aligns and sign/zero-extends the returned data, and drives a registered writeback. It sits directly downstream of the core configuration: `NrLoadBufEntries` and the scoreboard depth set its sizing.

## Interface
Parameters:
- `NrEntries`, 2, number of outstanding loads (power of two, 1..16).
- `TransIdWidth`, 3, scoreboard transaction ID width (log2 of scoreboard entries).
- `XLEN`, 64, data width.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `flush_i`  in  1  pipeline flush; kills all valid entries.
- `alloc_valid_i`  in  1  load requests an index.
- `alloc_ready_o`  out  1  a free index is available and `flush_i` is low.
- `alloc_trans_id_i`  in  TransIdWidth  scoreboard ID of the load.
- `alloc_size_i`  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- `alloc_offset_i`  in  3  byte offset within the 64-bit word.
- `alloc_sign_i`  in  1  1 = sign-extend, 0 = zero-extend.
- `alloc_id_o`  out  log2(NrEntries) (min 1)  index granted; valid when `alloc_valid_i && alloc_ready_o`.
- `kill_valid_i`  in  1  free one entry whose cache request was never issued.
- `kill_id_i`  in  log2(NrEntries)  entry to free.
- `rsp_valid_i`  in  1  cache response.
- `rsp_id_i`  in  log2(NrEntries)  index of the response.
- `rsp_data_i`  in  XLEN  raw 64-bit aligned word.
- `wb_valid_o`  out  1  writeback valid (single-cycle pulse).
- `wb_trans_id_o`  out  TransIdWidth  scoreboard ID of the writeback.
- `wb_data_o`  out  XLEN  aligned, extended result.
- `empty_o`  out  1  no valid entries.

## Operation
**Entry state**
- Each entry holds: `valid`, `killed`, trans_id, size, offset and sign.

**Allocation**
- A handshake occurs when `alloc_valid_i && alloc_ready_o`.
- The granted index is the lowest index whose `valid` is 0, evaluated on registered state.
- On the handshake the entry sets `valid`=1 and `killed`=0, and captures its fields.

**Response**
- A response to a valid entry frees that entry.
- If the entry is not killed, the writeback register loads the following:
  - `wb_trans_id_o` is the stored trans_id.
  - `wb_data_o` is `rsp_data_i >> (8*offset)`, truncated to the stored size.
  - Bits above the size are filled with the top data bit if sign=1, otherwise with 0.
  - Size 3 with XLEN=64 passes all 64 bits unchanged.
- A response to a killed entry frees the entry and produces no writeback.
- A response to an invalid entry is ignored.

**Kill**
- `kill_valid_i` clears `valid` of `kill_id_i` immediately, with no writeback.

**Flush**
- Every valid entry gets `killed`=1 and stays valid until its response arrives. This is needed because the cache still returns responses for requests already issued.
- A response in the same cycle as `flush_i` is treated as killed.
- A writeback already sitting in the output register is not cancelled.

**Simultaneous events**
- Alloc and response in the same cycle proceed independently.
- If kill and response target the same index, the response is dropped.

**Assertions**
- Allocation to a valid entry, and kill of an invalid entry, are assertion errors (simulation only).

## Timing
- After reset: all entries invalid; `wb_valid_o`=0, `wb_trans_id_o`=0, `wb_data_o`=0; `empty_o`=1; `alloc_ready_o`=1.
- `alloc_ready_o` and `alloc_id_o` are combinational from registered state and `flush_i`.
- Latency from response to writeback is 1 cycle: `rsp_valid_i` in cycle N gives `wb_valid_o` in cycle N+1.
- A freed entry is allocatable in the cycle after the free (without the bypass; see Configuration).
- Reset while entries are outstanding discards all state. Responses arriving after reset hit invalid entries and are ignored.
- `empty_o` is combinational: the NOR of all `valid` bits.

## Configuration
- **`LOAD_ID_TRACKER_BYPASS_EN` defined:**
  - When all entries are valid, a same-cycle non-killed or killed response (or kill) makes `alloc_ready_o`=1.
  - `alloc_id_o` is the freed index; if response and kill both free entries, it is the lower of the two.
  - Adds a combinational path from `rsp_valid_i`/`rsp_id_i` to `alloc_ready_o`.
- **Undefined:** `alloc_ready_o` depends only on registered `valid` bits and `flush_i`.

## Test plan
- **Signed byte load:** alloc trans_id=5, size=0, offset=3, sign=1 → id 0. Respond with `rsp_data_i`=64'h0000_0000_8000_0000 → one cycle later `wb_valid_o`=1, trans_id=5, data=64'hFFFF_FFFF_FFFF_FF80.
- **Zero-extended word:** size=2, offset=4, sign=0, data 64'hDEAD_BEEF_0000_0000 → data=64'h0000_0000_DEAD_BEEF.
- **Full buffer:** fill 2 entries → `alloc_ready_o`=0. Respond id 1 with a new alloc in the same cycle → stall (bypass off) or grant id 1 (bypass on). Next cycle, id 1 is granted.
- **Flush with outstanding loads:** 2 outstanding, pulse `flush_i` → `empty_o` stays 0. Both responses arrive → no `wb_valid_o`, then `empty_o`=1.
- **Kill:** kill id 0 → next cycle id 0 is allocatable. A stray response for id 0 is ignored.
- **Reset mid-operation:** 2 outstanding, assert `rst_i` for one cycle → all outputs at reset values, and subsequent responses produce no writeback.

Source files
------------

// File: rtl/load_id_tracker.sv
// Load buffer index tracker: grants an index per outstanding load, restores the scoreboard ID
// on the cache response, aligns and extends the data into a registered writeback.
// Optional macro LOAD_ID_TRACKER_BYPASS_EN lets an entry freed this cycle be re-granted at once.
module load_id_tracker #(
  parameter int NrEntries    = 2,
  parameter int TransIdWidth = 3,
  parameter int XLEN         = 64,
  localparam int IdW         = (NrEntries > 1) ? $clog2(NrEntries) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    alloc_valid_i,
  output logic                    alloc_ready_o,
  input  logic [TransIdWidth-1:0] alloc_trans_id_i,
  input  logic [1:0]              alloc_size_i,
  input  logic [2:0]              alloc_offset_i,
  input  logic                    alloc_sign_i,
  output logic [IdW-1:0]          alloc_id_o,
  input  logic                    kill_valid_i,
  input  logic [IdW-1:0]          kill_id_i,
  input  logic                    rsp_valid_i,
  input  logic [IdW-1:0]          rsp_id_i,
  input  logic [XLEN-1:0]         rsp_data_i,
  output logic                    wb_valid_o,
  output logic [TransIdWidth-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]         wb_data_o,
  output logic                    empty_o
);

  logic [NrEntries-1:0]    valid_q, valid_d;
  logic [NrEntries-1:0]    killed_q, killed_d;
  logic [TransIdWidth-1:0] trans_id_q [NrEntries];
  logic [1:0]              size_q     [NrEntries];
  logic [2:0]              offset_q   [NrEntries];
  logic                    sign_q     [NrEntries];

  logic                    wb_valid_q, wb_valid_d;
  logic [TransIdWidth-1:0] wb_trans_id_q, wb_trans_id_d;
  logic [XLEN-1:0]         wb_data_q, wb_data_d;

  logic [NrEntries-1:0] rsp_hit, kill_hit, alloc_hit, free_vec;
  logic                 handshake;
  logic                 any_free;
  logic [IdW-1:0]       free_idx;

  // Shift the addressed bytes down, keep 8<<size bits, fill above with sign or zero.
  function automatic logic [XLEN-1:0] align_extend(input logic [XLEN-1:0] word,
                                                   input logic [1:0]      size,
                                                   input logic [2:0]      offset,
                                                   input logic            sign);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] mask;
    logic            fill;
    int              nbits;
    sh = word >> {offset, 3'b000};
    unique case (size)
      2'd0:    begin nbits = 8;    fill = sh[7];      end
      2'd1:    begin nbits = 16;   fill = sh[15];     end
      2'd2:    begin nbits = 32;   fill = sh[31];     end
      default: begin nbits = XLEN; fill = sh[XLEN-1]; end
    endcase
    fill = fill & sign;
    if (nbits >= XLEN) mask = '1;
    else               mask = (XLEN'(1) << nbits) - XLEN'(1);
    return (sh & mask) | ({XLEN{fill}} & ~mask);
  endfunction

  // Per-entry decode of the index-carrying inputs.
  always_comb begin
    rsp_hit  = '0;
    kill_hit = '0;
    for (int i = 0; i < NrEntries; i++) begin
      rsp_hit[i]  = rsp_valid_i  && (rsp_id_i  == IdW'(i));
      kill_hit[i] = kill_valid_i && (kill_id_i == IdW'(i));
      free_vec[i] = valid_q[i] && (rsp_hit[i] || kill_hit[i]);
    end
  end

  // Lowest invalid entry; descending scan so the last write wins with the lowest index.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NrEntries - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_free = 1'b1;
        free_idx = IdW'(i);
      end
    end
  end

`ifdef LOAD_ID_TRACKER_BYPASS_EN
  logic           any_byp;
  logic [IdW-1:0] byp_idx;

  always_comb begin
    any_byp = 1'b0;
    byp_idx = '0;
    for (int i = NrEntries - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        any_byp = 1'b1;
        byp_idx = IdW'(i);
      end
    end
  end

  assign alloc_ready_o = !flush_i && (any_free || any_byp);
  assign alloc_id_o    = any_free ? free_idx : byp_idx;
`else
  assign alloc_ready_o = !flush_i && any_free;
  assign alloc_id_o    = free_idx;
`endif

  assign handshake = alloc_valid_i && alloc_ready_o;

  always_comb begin
    alloc_hit = '0;
    for (int i = 0; i < NrEntries; i++) begin
      alloc_hit[i] = handshake && (alloc_id_o == IdW'(i));
    end
  end

  // Allocation outranks a same-cycle free so a bypassed grant lands on the freed slot.
  always_comb begin
    valid_d  = valid_q;
    killed_d = killed_q;
    for (int i = 0; i < NrEntries; i++) begin
      if (alloc_hit[i]) begin
        valid_d[i]  = 1'b1;
        killed_d[i] = 1'b0;
      end else if (free_vec[i]) begin
        valid_d[i] = 1'b0;
      end else if (flush_i && valid_q[i]) begin
        killed_d[i] = 1'b1;
      end
    end
  end

  // Response path: select the addressed entry's fields and build the writeback.
  always_comb begin
    logic                    hit_valid;
    logic                    hit_killed;
    logic [1:0]              hit_size;
    logic [2:0]              hit_offset;
    logic                    hit_sign;
    hit_valid     = 1'b0;
    hit_killed    = 1'b0;
    hit_size      = '0;
    hit_offset    = '0;
    hit_sign      = 1'b0;
    wb_trans_id_d = '0;
    for (int i = 0; i < NrEntries; i++) begin
      if (rsp_id_i == IdW'(i)) begin
        hit_valid     = valid_q[i];
        hit_killed    = killed_q[i];
        hit_size      = size_q[i];
        hit_offset    = offset_q[i];
        hit_sign      = sign_q[i];
        wb_trans_id_d = trans_id_q[i];
      end
    end
    wb_valid_d = rsp_valid_i && hit_valid && !hit_killed && !flush_i &&
                 !(kill_valid_i && (kill_id_i == rsp_id_i));
    wb_data_d  = align_extend(rsp_data_i, hit_size, hit_offset, hit_sign);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q       <= '0;
      killed_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_trans_id_q <= '0;
      wb_data_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      killed_q   <= killed_d;
      wb_valid_q <= wb_valid_d;
      if (wb_valid_d) begin
        wb_trans_id_q <= wb_trans_id_d;
        wb_data_q     <= wb_data_d;
      end
    end
  end

  // NOTE: payload fields are only read while their valid bit is set, so they carry no reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NrEntries; i++) begin
      if (alloc_hit[i]) begin
        trans_id_q[i] <= alloc_trans_id_i;
        size_q[i]     <= alloc_size_i;
        offset_q[i]   <= alloc_offset_i;
        sign_q[i]     <= alloc_sign_i;
      end
    end
  end

  assign wb_valid_o    = wb_valid_q;
  assign wb_trans_id_o = wb_trans_id_q;
  assign wb_data_o     = wb_data_q;
  assign empty_o       = ~|valid_q;

`ifndef SYNTHESIS
  a_alloc_free_entry : assert property (@(posedge clk_i) disable iff (rst_i)
    handshake |-> ((alloc_hit & valid_q & ~free_vec) == '0))
    else $error("load_id_tracker: allocation to a valid entry");

  a_kill_valid_entry : assert property (@(posedge clk_i) disable iff (rst_i)
    kill_valid_i |-> |(kill_hit & valid_q))
    else $error("load_id_tracker: kill of an invalid entry");
`endif

endmodule

// File: tb/tb_load_id_tracker.sv
// Directed bench for load_id_tracker: stimulus pushes expected writebacks into a queue,
// a negedge monitor pops and compares every wb_valid_o pulse.
module tb_load_id_tracker;

  localparam int NrEntries    = 2;
  localparam int TransIdWidth = 3;
  localparam int XLEN         = 64;
  localparam int IdW          = 1;

  typedef struct {
    logic [TransIdWidth-1:0] tid;
    logic [XLEN-1:0]         data;
  } exp_t;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    flush_i = 1'b0;
  logic                    alloc_valid_i = 1'b0;
  logic                    alloc_ready_o;
  logic [TransIdWidth-1:0] alloc_trans_id_i = '0;
  logic [1:0]              alloc_size_i = '0;
  logic [2:0]              alloc_offset_i = '0;
  logic                    alloc_sign_i = 1'b0;
  logic [IdW-1:0]          alloc_id_o;
  logic                    kill_valid_i = 1'b0;
  logic [IdW-1:0]          kill_id_i = '0;
  logic                    rsp_valid_i = 1'b0;
  logic [IdW-1:0]          rsp_id_i = '0;
  logic [XLEN-1:0]         rsp_data_i = '0;
  logic                    wb_valid_o;
  logic [TransIdWidth-1:0] wb_trans_id_o;
  logic [XLEN-1:0]         wb_data_o;
  logic                    empty_o;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  load_id_tracker #(
    .NrEntries   (NrEntries),
    .TransIdWidth(TransIdWidth),
    .XLEN        (XLEN)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .alloc_valid_i   (alloc_valid_i),
    .alloc_ready_o   (alloc_ready_o),
    .alloc_trans_id_i(alloc_trans_id_i),
    .alloc_size_i    (alloc_size_i),
    .alloc_offset_i  (alloc_offset_i),
    .alloc_sign_i    (alloc_sign_i),
    .alloc_id_o      (alloc_id_o),
    .kill_valid_i    (kill_valid_i),
    .kill_id_i       (kill_id_i),
    .rsp_valid_i     (rsp_valid_i),
    .rsp_id_i        (rsp_id_i),
    .rsp_data_i      (rsp_data_i),
    .wb_valid_o      (wb_valid_o),
    .wb_trans_id_o   (wb_trans_id_o),
    .wb_data_o       (wb_data_o),
    .empty_o         (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_alloc(input logic [2:0] tid, input logic [1:0] size,
                           input logic [2:0] off, input logic sign);
    alloc_valid_i    = 1'b1;
    alloc_trans_id_i = tid;
    alloc_size_i     = size;
    alloc_offset_i   = off;
    alloc_sign_i     = sign;
  endtask

  task automatic set_rsp(input logic [IdW-1:0] id, input logic [63:0] data);
    rsp_valid_i = 1'b1;
    rsp_id_i    = id;
    rsp_data_i  = data;
  endtask

  task automatic expect_wb(input logic [2:0] tid, input logic [63:0] data);
    exp_t e;
    e.tid  = tid;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every writeback pulse must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (wb_valid_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wb: got tid %0d data %h expected no writeback",
                 wb_trans_id_o, wb_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_trans_id", 64'(wb_trans_id_o), 64'(e.tid));
        check("wb_data", wb_data_o, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_wb_tid", 64'(wb_trans_id_o), 64'd0);
    check("rst_wb_data", wb_data_o, 64'd0);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_ready", 64'(alloc_ready_o), 64'd1);

    // Signed byte load
    set_alloc(3'd5, 2'd0, 3'd3, 1'b1);
    #1;
    check("byte_alloc_id", 64'(alloc_id_o), 64'd0);
    tick();
    alloc_valid_i = 1'b0;
    #1;
    check("byte_not_empty", 64'(empty_o), 64'd0);
    set_rsp(1'b0, 64'h0000_0000_8000_0000);
    expect_wb(3'd5, 64'hFFFF_FFFF_FFFF_FF80);
    tick();
    rsp_valid_i = 1'b0;
    check("byte_wb_latency", 64'(wb_valid_o), 64'd1);
    check("byte_empty_after", 64'(empty_o), 64'd1);

    // Zero-extended word on id 0, signed half on id 1, answered out of order
    set_alloc(3'd2, 2'd2, 3'd4, 1'b0);
    tick();
    set_alloc(3'd3, 2'd1, 3'd6, 1'b1);
    #1;
    check("half_alloc_id", 64'(alloc_id_o), 64'd1);
    tick();
    alloc_valid_i = 1'b0;
    set_rsp(1'b1, 64'h7FFF_0000_0000_0000);
    expect_wb(3'd3, 64'h0000_0000_0000_7FFF);
    tick();
    set_rsp(1'b0, 64'hDEAD_BEEF_0000_0000);
    expect_wb(3'd2, 64'h0000_0000_DEAD_BEEF);
    tick();
    rsp_valid_i = 1'b0;

    // Full buffer
    set_alloc(3'd1, 2'd1, 3'd2, 1'b0);
    tick();
    set_alloc(3'd4, 2'd0, 3'd0, 1'b0);
    tick();
    alloc_valid_i = 1'b0;
    #1;
    check("full_ready", 64'(alloc_ready_o), 64'd0);
    set_rsp(1'b1, 64'h0000_0000_0000_00AB);
    expect_wb(3'd4, 64'h0000_0000_0000_00AB);
    set_alloc(3'd6, 2'd3, 3'd0, 1'b0);
    #1;
`ifdef LOAD_ID_TRACKER_BYPASS_EN
    check("full_bypass_ready", 64'(alloc_ready_o), 64'd1);
    check("full_bypass_id", 64'(alloc_id_o), 64'd1);
    tick();
    rsp_valid_i   = 1'b0;
    alloc_valid_i = 1'b0;
`else
    check("full_stall", 64'(alloc_ready_o), 64'd0);
    tick();
    rsp_valid_i = 1'b0;
    #1;
    check("freed_ready", 64'(alloc_ready_o), 64'd1);
    check("freed_id", 64'(alloc_id_o), 64'd1);
    tick();
    alloc_valid_i = 1'b0;
`endif
    set_rsp(1'b1, 64'h1122_3344_5566_7788);
    expect_wb(3'd6, 64'h1122_3344_5566_7788);
    tick();
    set_rsp(1'b0, 64'h0000_0000_F00D_0000);
    expect_wb(3'd1, 64'h0000_0000_0000_F00D);
    tick();
    rsp_valid_i = 1'b0;
    #1;
    check("full_drained_empty", 64'(empty_o), 64'd1);

    // A writeback already in the output register survives a flush
    set_alloc(3'd5, 2'd3, 3'd0, 1'b1);
    tick();
    alloc_valid_i = 1'b0;
    set_rsp(1'b0, 64'hCAFE_F00D_1234_5678);
    expect_wb(3'd5, 64'hCAFE_F00D_1234_5678);
    tick();
    rsp_valid_i = 1'b0;
    flush_i     = 1'b1;
    #1;
    check("flush_keeps_wb", 64'(wb_valid_o), 64'd1);
    check("flush_ready", 64'(alloc_ready_o), 64'd0);
    tick();
    flush_i = 1'b0;

    // Flush with two outstanding loads; id 0 responds in the flush cycle
    set_alloc(3'd0, 2'd0, 3'd0, 1'b0);
    tick();
    set_alloc(3'd1, 2'd0, 3'd0, 1'b0);
    tick();
    alloc_valid_i = 1'b0;
    flush_i       = 1'b1;
    set_rsp(1'b0, 64'h0000_0000_0000_0011);
    tick();
    flush_i     = 1'b0;
    rsp_valid_i = 1'b0;
    #1;
    check("flush_not_empty", 64'(empty_o), 64'd0);
    set_rsp(1'b1, 64'h0000_0000_0000_0022);
    tick();
    rsp_valid_i = 1'b0;
    #1;
    check("flush_drained_empty", 64'(empty_o), 64'd1);

    // Kill, then a stray response for the killed id
    set_alloc(3'd2, 2'd0, 3'd0, 1'b0);
    tick();
    alloc_valid_i = 1'b0;
    kill_valid_i  = 1'b1;
    kill_id_i     = 1'b0;
    tick();
    kill_valid_i = 1'b0;
    #1;
    check("kill_ready", 64'(alloc_ready_o), 64'd1);
    check("kill_id_reuse", 64'(alloc_id_o), 64'd0);
    check("kill_empty", 64'(empty_o), 64'd1);
    set_rsp(1'b0, 64'h0000_0000_0000_0033);
    tick();
    rsp_valid_i = 1'b0;

    // Kill and response on the same index: response dropped
    set_alloc(3'd3, 2'd0, 3'd0, 1'b0);
    tick();
    alloc_valid_i = 1'b0;
    kill_valid_i  = 1'b1;
    kill_id_i     = 1'b0;
    set_rsp(1'b0, 64'h0000_0000_0000_0044);
    tick();
    kill_valid_i = 1'b0;
    rsp_valid_i  = 1'b0;
    #1;
    check("kill_rsp_empty", 64'(empty_o), 64'd1);

    // Reset mid-operation
    set_alloc(3'd5, 2'd0, 3'd0, 1'b0);
    tick();
    set_alloc(3'd6, 2'd0, 3'd0, 1'b0);
    tick();
    alloc_valid_i = 1'b0;
    rst_i         = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check("midrst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("midrst_wb_tid", 64'(wb_trans_id_o), 64'd0);
    check("midrst_wb_data", wb_data_o, 64'd0);
    check("midrst_empty", 64'(empty_o), 64'd1);
    check("midrst_ready", 64'(alloc_ready_o), 64'd1);
    set_rsp(1'b0, 64'h0000_0000_0000_0055);
    tick();
    set_rsp(1'b1, 64'h0000_0000_0000_0066);
    tick();
    rsp_valid_i = 1'b0;
    #1;
    check("midrst_still_empty", 64'(empty_o), 64'd1);

    tick();
    tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
